// File: rtl/simd_bram_pkg.sv
// Shared types and defaults for the single-port BRAM arbiter.
package simd_bram_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int DEPTH_DEF      = 256;
  localparam int NUM_REQ_DEF    = 2;
  localparam int ADDR_W_DEF     = $clog2(DEPTH_DEF);

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

  typedef struct packed {
    logic                      we;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } bram_req_t;

endpackage

// File: rtl/bram_arb_grant.sv
// Picks one requester per cycle. BRAM_ARB_RR_EN selects round-robin from a
// pointer; otherwise fixed priority with the lowest index winning.
module bram_arb_grant import simd_bram_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
`ifdef BRAM_ARB_RR_EN
  input  logic               clk,
  input  logic               rst_n,
`endif
  input  logic [NUM_REQ-1:0] vld,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

`ifdef BRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  int               j;

  // Search starts at ptr, so the previous winner is checked last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && vld[IDX_W'(j)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (gnt_any)
      ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (vld[IDX_W'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt          = '0;
    gnt[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one read-first single-port BRAM among NUM_REQ requesters; responses
// return one cycle after acceptance. Arbitration mode set by BRAM_ARB_RR_EN.
module bram_arbiter import simd_bram_pkg::*; #(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic                                rsp_we,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [ADDR_W-1:0]                   bram_addr,
  output logic                                bram_we,
  output logic [DATA_WIDTH-1:0]               bram_data_in,
  input  logic [DATA_WIDTH-1:0]               bram_data_out,
  output logic                                busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [NUM_REQ-1:0] vld, gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  req_t               sel;

  // Masking valid during reset keeps ready and bram_we low without extra gating.
  assign vld = rst_n ? req_valid : '0;

  bram_arb_grant #(.NUM_REQ(NUM_REQ)) u_grant (
`ifdef BRAM_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .vld     (vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Idle drives all-zero onto the BRAM port.
  always_comb begin
    sel = '0;
    if (gnt_any) begin
      sel.we    = req_we[gnt_idx];
      sel.addr  = req_addr[gnt_idx];
      sel.wdata = req_wdata[gnt_idx];
    end
  end

  assign req_ready    = gnt;
  assign bram_addr    = sel.addr;
  assign bram_we      = sel.we;
  assign bram_data_in = sel.wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_we    <= 1'b0;
    end else begin
      rsp_valid <= gnt;
      rsp_we    <= sel.we;
    end
  end

  assign rsp_rdata = bram_data_out;
  assign busy      = (|req_valid) | (|rsp_valid);

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a read-first BRAM model; expectations
// follow BRAM_ARB_RR_EN when defined.
module tb_bram_arbiter;
  import simd_bram_pkg::*;

  localparam int NR = 2;
  localparam int DW = 128;
  localparam int AW = 8;

  logic                   clk, rst_n;
  logic [NR-1:0]          req_valid, req_ready, req_we, rsp_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic                   rsp_we, bram_we, busy;
  logic [DW-1:0]          rsp_rdata, bram_data_in, bram_data_out;
  logic [AW-1:0]          bram_addr;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] exp_mem [256];
  logic [1:0]    exp_g   [4];
  int            n_pass, n_chk;

  bram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port BRAM, 1-cycle read latency.
  always @(posedge clk) begin
    bram_data_out <= mem[bram_addr];
    if (bram_we) mem[bram_addr] <= bram_data_in;
  end

  function automatic logic [DW-1:0] pat(input int i);
    return {4{32'hA5A5_0000 | i}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  localparam logic [DW-1:0] B = {4{32'hB0B0_C0DE}};

  initial begin
    n_pass = 0; n_chk = 0;
    for (int i = 0; i < 256; i++) begin mem[i] = pat(i); exp_mem[i] = pat(i); end
`ifdef BRAM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // reset: requests present but nothing granted or written
    for (int c = 0; c < 2; c++) begin
      tick(); req_valid = 2'b11; req_we = 2'b11;
      settle();
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_bram_we", bram_we, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_we", rsp_we, 1'b0);
    end

    tick(); rst_n = 1'b1; req_valid = '0; req_we = '0;
    settle();
    chk("idle_busy", busy, 1'b0);
    chk("idle_bram_we", bram_we, 1'b0);
    chk("idle_bram_addr", bram_addr, 8'h00);
    chk("idle_rsp_valid", rsp_valid, 2'b00);

    // 1: single read
    tick(); req_valid = 2'b01; req_addr[0] = 8'h10;
    settle();
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_bram_addr", bram_addr, 8'h10);
    chk("rd_bram_we", bram_we, 1'b0);
    tick(); req_valid = '0;
    settle();
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_we", rsp_we, 1'b0);
    chk("rd_rdata", rsp_rdata, pat(16));
    chk("rd_busy", busy, 1'b1);
    tick();
    settle();
    chk("rd_rsp_drop", rsp_valid, 2'b00);

    // 2: req1 writes 0x20 then reads it back
    tick(); req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 8'h20; req_wdata[1] = B;
    settle();
    chk("wr_ready", req_ready, 2'b10);
    chk("wr_bram_we", bram_we, 1'b1);
    chk("wr_bram_din", bram_data_in, B);
    exp_mem[32] = B;
    tick(); req_we = 2'b00;
    settle();
    chk("wr_rsp_valid", rsp_valid, 2'b10);
    chk("wr_rsp_we", rsp_we, 1'b1);
    chk("wr_old_word", rsp_rdata, pat(32));
    chk("rb_bram_we", bram_we, 1'b0);
    chk("rb_ready", req_ready, 2'b10);
    tick(); req_valid = '0;
    settle();
    chk("rb_rsp_valid", rsp_valid, 2'b10);
    chk("rb_rsp_we", rsp_we, 1'b0);
    chk("rb_rdata", rsp_rdata, B);
    chk("rb_idle_we", bram_we, 1'b0);

    // 3: contention for 4 cycles
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k < 4) begin req_valid = 2'b11; req_addr[0] = 8'h30; req_addr[1] = 8'h31; end
      else req_valid = '0;
      settle();
      if (k < 4) chk($sformatf("cont_ready%0d", k), req_ready, exp_g[k]);
      if (k > 0) begin
        chk($sformatf("cont_rsp%0d", k-1), rsp_valid, exp_g[k-1]);
        chk($sformatf("cont_data%0d", k-1), rsp_rdata,
            (exp_g[k-1] == 2'b01) ? exp_mem[48] : exp_mem[49]);
      end
    end

    // 4: reset lands on the edge that would launch a read response
    tick(); req_valid = 2'b01; req_addr[0] = 8'h40;
    settle();
    chk("mr_ready", req_ready, 2'b01);
    #1 rst_n = 1'b0;
    tick(); req_valid = 2'b11;
    settle();
    chk("mr_rsp_dropped", rsp_valid, 2'b00);
    chk("mr_ready_in_rst", req_ready, 2'b00);
    tick(); rst_n = 1'b1;
    settle();
    chk("mr_rsp_after", rsp_valid, 2'b00);
    chk("mr_ptr_reset", req_ready, 2'b01);

    // 5: hold fields while the other requester is served
    tick(); req_valid = 2'b11; req_addr[0] = 8'h55; req_addr[1] = 8'h66;
    settle();
`ifdef BRAM_ARB_RR_EN
    chk("hold_ready_a", req_ready, 2'b10);
    chk("hold_addr_a", bram_addr, 8'h66);
    tick(); req_valid = 2'b01;
    settle();
    chk("hold_ready_b", req_ready, 2'b01);
    chk("hold_addr_b", bram_addr, 8'h55);
`else
    chk("hold_ready_a", req_ready, 2'b01);
    chk("hold_addr_a", bram_addr, 8'h55);
    tick(); req_valid = 2'b10;
    settle();
    chk("hold_ready_b", req_ready, 2'b10);
    chk("hold_addr_b", bram_addr, 8'h66);
`endif
    tick(); req_valid = '0;
    tick();
    settle();
    chk("idle2_busy", busy, 1'b0);
    chk("idle2_rsp_valid", rsp_valid, 2'b00);
    chk("idle2_bram_we", bram_we, 1'b0);
    chk("idle2_bram_addr", bram_addr, 8'h00);
    chk("idle2_bram_din", bram_data_in, '0);

    // 6: stream all 256 words through req0
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i <= 256; i++) begin
        tick();
        if (i < 256) begin req_valid = 2'b01; req_we = '0; req_addr[0] = AW'(i); end
        else req_valid = '0;
        settle();
        if (i < 256) chk($sformatf("st_ready%0d", i), req_ready, 2'b01);
        if (i > 0) begin
          if (rsp_valid == 2'b01) pulses++;
          chk($sformatf("st_data%0d", i-1), rsp_rdata, exp_mem[i-1]);
        end
      end
      chk("st_pulses", pulses, 256);
      tick();
      settle();
      chk("st_end_rsp", rsp_valid, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
